// File: rtl/j_fifo.sv
// j_fifo: single-clock FIFO with registered read data and count-decoded
// full/empty flags. Writes are dropped while full and reads are dropped
// while empty. An accepted read returns the oldest entry on the same edge.
module j_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  output logic [DATA_WIDTH-1:0] DATAOUT,
  output logic                  full,
  output logic                  empty,
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wn,
  input  logic                  rn,
  input  logic [DATA_WIDTH-1:0] DATAIN
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_ok;
  logic                  rd_ok;

  // Qualify enables with the registered status flags.
  always_comb begin
    wr_ok = wn & ~full;
    rd_ok = rn & ~empty;
  end

  // Decode the flags from the registered occupancy count.
  always_comb begin
    empty = (count == '0);
    full  = (count == (ADDR_WIDTH+1)'(DEPTH));
  end

  // Storage array. It has no reset, and it is written only on an accepted write.
  always_ff @(posedge clock) begin
    if (!reset && wr_ok)
      mem[wptr] <= DATAIN;
  end

  // Pointers, occupancy and registered read data. Reset takes priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      DATAOUT <= '0;
    end else begin
      if (wr_ok)
        wptr <= wptr + 1'b1;
      if (rd_ok) begin
        DATAOUT <= mem[rptr];
        rptr    <= rptr + 1'b1;
      end
      if (wr_ok && !rd_ok)
        count <= count + 1'b1;
      else if (rd_ok && !wr_ok)
        count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_j_fifo.sv
// tb_j_fifo: directed bench for j_fifo. A queue scoreboard holds the
// expected FIFO contents. It predicts DATAOUT, full and empty after every edge.
module tb_j_fifo;

  logic [7:0] DATAOUT;
  logic       full;
  logic       empty;
  logic       clock;
  logic       reset;
  logic       wn;
  logic       rn;
  logic [7:0] DATAIN;

  int unsigned compared;
  int unsigned mismatched;

  logic [7:0] sb [$];
  logic [7:0] exp_out;

  j_fifo #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .DATAOUT(DATAOUT),
    .full   (full),
    .empty  (empty),
    .clock  (clock),
    .reset  (reset),
    .wn     (wn),
    .rn     (rn),
    .DATAIN (DATAIN)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dataout"}, DATAOUT, exp_out);
    chk({tag, ".full"},    {7'd0, full},  {7'd0, (sb.size() == 8)});
    chk({tag, ".empty"},   {7'd0, empty}, {7'd0, (sb.size() == 0)});
  endtask

  // Drive one cycle, update the scoreboard, then sample after the edge.
  task automatic step(input string tag, input logic w, input logic r, input logic [7:0] d);
    bit wr_acc, rd_acc;
    @(negedge clock);
    reset = 1'b0; wn = w; rn = r; DATAIN = d;
    wr_acc = w && (sb.size() < 8);
    rd_acc = r && (sb.size() > 0);
    if (rd_acc) exp_out = sb.pop_front();
    if (wr_acc) sb.push_back(d);
    @(posedge clock); #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic w, input logic r);
    @(negedge clock);
    reset = 1'b1; wn = w; rn = r; DATAIN = 8'hFF;
    sb.delete();
    exp_out = 8'h00;
    @(posedge clock); #1;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] vals2 [7];
    compared = 0; mismatched = 0;
    reset = 1'b1; wn = 1'b0; rn = 1'b0; DATAIN = 8'h00;
    exp_out = 8'h00;
    vals2 = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};

    // Reset state, with unknown enables during the reset edge.
    do_reset("reset", 1'bx, 1'bx);

    // In-order data, and a read while empty.
    foreach (vals2[i]) step("t2.wr", 1'b1, 1'b0, vals2[i]);
    for (int i = 0; i < 7; i++) step("t2.rd", 1'b0, 1'b1, 8'h00);
    step("t2.rd_empty", 1'b0, 1'b1, 8'h00);
    chk("t2.hold15", DATAOUT, 8'd15);

    // Fill to full, write once more (ignored), then drain all 8 entries.
    for (int i = 0; i < 8; i++) step("t3.wr", 1'b1, 1'b0, 8'(8'h10 + i));
    chk("t3.full", {7'd0, full}, 8'd1);
    step("t3.wr_full", 1'b1, 1'b0, 8'hEE);
    for (int i = 0; i < 8; i++) step("t3.rd", 1'b0, 1'b1, 8'h00);
    chk("t3.last", DATAOUT, 8'h17);

    // Wrap-around across the pointer boundary.
    for (int i = 0; i < 6; i++) step("t4.wr6", 1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 6; i++) step("t4.rd6", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) step("t4.wr8", 1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 8; i++) step("t4.rd8", 1'b0, 1'b1, 8'h00);
    chk("t4.last", DATAOUT, 8'hA7);

    // Simultaneous read and write with 3 entries, then with the FIFO empty.
    for (int i = 0; i < 3; i++) step("t5.wr", 1'b1, 1'b0, 8'(8'h50 + i));
    step("t5.both", 1'b1, 1'b1, 8'h53);
    chk("t5.oldest", DATAOUT, 8'h50);
    for (int i = 0; i < 3; i++) step("t5.rd", 1'b0, 1'b1, 8'h00);
    step("t5.both_empty", 1'b1, 1'b1, 8'h77);
    chk("t5.not_empty", {7'd0, empty}, 8'd0);
    step("t5.rd77", 1'b0, 1'b1, 8'h00);
    chk("t5.val77", DATAOUT, 8'h77);

    // Simultaneous read and write while full: the write is dropped.
    for (int i = 0; i < 8; i++) step("t7.wr", 1'b1, 1'b0, 8'(8'hC0 + i));
    step("t7.both_full", 1'b1, 1'b1, 8'hDD);
    for (int i = 0; i < 7; i++) step("t7.rd", 1'b0, 1'b1, 8'h00);
    chk("t7.last", DATAOUT, 8'hC7);

    // Reset in the middle of a stream, then reuse the FIFO.
    for (int i = 0; i < 4; i++) step("t6.wr", 1'b1, 1'b0, 8'(8'h60 + i));
    do_reset("t6.reset", 1'b1, 1'b1);
    step("t6.wr5a", 1'b1, 1'b0, 8'h5A);
    step("t6.rd5a", 1'b0, 1'b1, 8'h00);
    chk("t6.val5a", DATAOUT, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
